// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Conditions one raw pushbutton into a clean debounced level plus one-cycle
// press / release pulses. The raw input is brought into the clk domain by a
// two-flop synchronizer. The debounced level flips only after the
// synchronized input has disagreed with it for DEBOUNCE_CYCLES consecutive
// cycles.
//
// Optional feature (macro AUTO_REPEAT_EN): while the button stays held,
// extra press pulses are generated. The first comes REPEAT_DELAY cycles
// after the press pulse, and the rest follow every REPEAT_PERIOD cycles.
// Each of these is also flagged on repeat_pulse. Without the macro,
// repeat_pulse is tied low and no repeat logic exists.
//
// Handshake: none. Every output is a registered level or one-cycle strobe
// that is valid on each rising edge of clk. There is no back-pressure.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset (priority over all)
//   button       in   raw pushbutton, asynchronous, may bounce
//   level        out  debounced button state, 1 = held
//   pressed      out  one-cycle pulse on debounced press (and on repeats)
//   released     out  one-cycle pulse on debounced release
//   repeat_pulse out  one-cycle pulse on auto-repeat pulses only
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic pressed,
    output logic released,
    output logic repeat_pulse
);

    // Catch illegal parameter values at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Bit 1 of the encoding is the debounced level, so level is a flop output.
    typedef enum logic [1:0] {
        RELEASED        = 2'b00,
        PRESS_PENDING   = 2'b01,
        HELD            = 2'b10,
        RELEASE_PENDING = 2'b11
    } state_t;

    state_t          state_q;
    logic            s1_q;
    logic            s2_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            pressed_q;
    logic            released_q;
    logic            level_now;
    logic            disagree;
    logic            done;
    logic            rep_fire;

    assign level_now = state_q[1];
    assign disagree  = (s2_q != level_now);
    // The count has completed. The level flips and the counter clears on this edge.
    assign done      = disagree && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = '0;
        if (disagree && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronizer, stability counter, state and press/release strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            cnt_q      <= '0;
            state_q    <= RELEASED;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            s1_q  <= button;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            if (done) begin
                state_q <= level_now ? RELEASED : HELD;
            end else if (disagree) begin
                state_q <= level_now ? RELEASE_PENDING : PRESS_PENDING;
            end else begin
                state_q <= level_now ? HELD : RELEASED;
            end
            pressed_q  <= (done && !level_now) || rep_fire;
            released_q <= done && level_now;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q;
    logic [RW-1:0] rep_target;
    logic          rep_first_q;   // first repeat has already fired
    logic          repeat_q;

    assign rep_target = rep_first_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    // A repeat only fires from a stable HELD state. It never fires on a
    // release edge, so it cannot coincide with a release pulse.
    assign rep_fire   = (state_q == HELD) && !done && (rep_cnt_q == rep_target);

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            repeat_q <= rep_fire;
            case (state_q)
                HELD: begin
                    if (rep_fire) begin
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                    end
                end
                // Freeze during a possible release so a bounce does not restart the delay.
                RELEASE_PENDING: begin
                    rep_cnt_q   <= rep_cnt_q;
                    rep_first_q <= rep_first_q;
                end
                default: begin
                    rep_cnt_q   <= '0;
                    rep_first_q <= 1'b0;
                end
            endcase
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign rep_fire     = 1'b0;
    assign repeat_pulse = 1'b0;
`endif

    assign level    = level_now;
    assign pressed  = pressed_q;
    assign released = released_q;

endmodule
